// File: rtl/uart_trx.sv
// Full-duplex UART transceiver with runtime frame format, TX/RX FIFOs and per-frame error flags.
// Both FSMs run on clk; every bit lasts div+1 cycles (div clamped to a minimum of 3).

module uart_trx_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wp_q, rp_q;
  logic         do_push, do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  // A pop on an empty FIFO is dropped, so push+pop while empty never passes data through.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end
endmodule

module uart_trx #(
  parameter int DMSB = 7,
  parameter int CMSB = 12,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          setn,
  input  logic [CMSB:0] div,
  input  logic [3:0]    nbits,
  input  logic [1:0]    par,
  input  logic          stop2,
  input  logic          tx_push,
  input  logic [DMSB:0] tx_wdata,
  output logic          tx_full,
  output logic          tx_empty,
  input  logic          rx_pop,
  output logic [DMSB:0] rx_rdata,
  output logic          rx_perr,
  output logic          rx_ferr,
  output logic          rx_empty,
  output logic          rx_ovf,
  input  logic          clear,
  output logic          tx,
  input  logic          rx
);
  localparam int W  = DMSB + 1;
  localparam int BW = $clog2(W);
  localparam logic [CMSB:0] DIV_MIN = (CMSB+1)'(3);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_e;

  function automatic logic calc_par(input logic [W-1:0] d, input logic [BW-1:0] nb, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < W; i++) if (i <= int'(nb)) p ^= d[i];
    return p;
  endfunction

  logic [CMSB:0] div_eff;
  logic [BW-1:0] nb_eff;
  logic          kill;

  assign div_eff = (div < DIV_MIN) ? DIV_MIN : div;
  assign nb_eff  = BW'((nbits > 4'(DMSB)) ? 4'(DMSB) : ((nbits < 4'd4) ? 4'd4 : nbits));
  assign kill    = clear | ~setn;

  // ---------------- transmitter ----------------
  tx_state_e     ts_q, ts_d;
  logic [CMSB:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d;
  logic [BW-1:0] tnb_q, tnb_d, tbit_q, tbit_d;
  logic [W-1:0]  tsh_q, tsh_d, txf_head;
  logic          tpen_q, tpen_d, tstop2_q, tstop2_d, tpbit_q, tpbit_d, tx_q, tx_d;
  logic          txf_pop, txf_empty, tload, tend;

  uart_trx_fifo #(.W(W), .AW(AW)) u_txf (
    .clk(clk), .rstn(rstn), .flush_i(kill), .push_i(tx_push), .wdata_i(tx_wdata),
    .pop_i(txf_pop), .rdata_o(txf_head), .full_o(tx_full), .empty_o(txf_empty)
  );

  always_comb begin
    ts_d = ts_q; tcnt_d = tcnt_q; tdiv_d = tdiv_q; tnb_d = tnb_q; tbit_d = tbit_q;
    tsh_d = tsh_q; tpen_d = tpen_q; tstop2_d = tstop2_q; tpbit_d = tpbit_q;
    txf_pop = 1'b0; tload = 1'b0; tx_d = 1'b1;
    tend = (tcnt_q == tdiv_q);
    if (ts_q != S_IDLE) tcnt_d = tend ? '0 : tcnt_q + 1'b1;
    case (ts_q)
      S_IDLE:  tload = ~txf_empty;
      S_START: if (tend) begin ts_d = S_DATA; tbit_d = '0; end
      S_DATA: if (tend) begin
        tsh_d  = tsh_q >> 1;
        tbit_d = tbit_q + 1'b1;
        if (tbit_q == tnb_q) ts_d = tpen_q ? S_PAR : S_STOP1;
      end
      S_PAR:   if (tend) ts_d = S_STOP1;
      S_STOP1: if (tend) begin
        if (tstop2_q) ts_d = S_STOP2;
        else begin ts_d = S_IDLE; tload = ~txf_empty; end
      end
      S_STOP2: if (tend) begin ts_d = S_IDLE; tload = ~txf_empty; end
      default: ts_d = S_IDLE;
    endcase
    if (kill) begin ts_d = S_IDLE; tload = 1'b0; end
    // Loading straight from a stop bit end gives back-to-back frames with no idle gap.
    if (tload) begin
      txf_pop  = 1'b1;
      ts_d     = S_START;
      tcnt_d   = '0;
      tdiv_d   = div_eff;
      tnb_d    = nb_eff;
      tpen_d   = ^par;
      tstop2_d = stop2;
      tsh_d    = txf_head;
      tpbit_d  = calc_par(txf_head, nb_eff, par == 2'b10);
    end
    case (ts_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tsh_d[0];
      S_PAR:   tx_d = tpbit_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_q <= S_IDLE; tcnt_q <= '0; tdiv_q <= '0; tnb_q <= '0; tbit_q <= '0; tsh_q <= '0;
      tpen_q <= 1'b0; tstop2_q <= 1'b0; tpbit_q <= 1'b0; tx_q <= 1'b1;
    end else begin
      ts_q <= ts_d; tcnt_q <= tcnt_d; tdiv_q <= tdiv_d; tnb_q <= tnb_d; tbit_q <= tbit_d;
      tsh_q <= tsh_d; tpen_q <= tpen_d; tstop2_q <= tstop2_d; tpbit_q <= tpbit_d; tx_q <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_empty = txf_empty && (ts_q == S_IDLE);

  // ---------------- receiver ----------------
  rx_state_e     rs_q, rs_d;
  logic [CMSB:0] rcnt_q, rcnt_d, rdiv_q, rdiv_d;
  logic [BW-1:0] rnb_q, rnb_d, rbit_q, rbit_d;
  logic [W-1:0]  rdat_q, rdat_d;
  logic          rpen_q, rpen_d, rodd_q, rodd_d, rperr_q, rperr_d, ovf_q, ovf_d;
  logic          rx_m_q, rx_s_q, rx_p_q, rstore, rferr, rend, rmid, rxf_full;

  uart_trx_fifo #(.W(W+2), .AW(AW)) u_rxf (
    .clk(clk), .rstn(rstn), .flush_i(kill), .push_i(rstore), .wdata_i({rferr, rperr_q, rdat_q}),
    .pop_i(rx_pop), .rdata_o({rx_ferr, rx_perr, rx_rdata}), .full_o(rxf_full), .empty_o(rx_empty)
  );

  always_comb begin
    rs_d = rs_q; rcnt_d = rcnt_q; rdiv_d = rdiv_q; rnb_d = rnb_q; rbit_d = rbit_q;
    rdat_d = rdat_q; rpen_d = rpen_q; rodd_d = rodd_q; rperr_d = rperr_q;
    rstore = 1'b0; rferr = 1'b0; ovf_d = ovf_q;
    rend = (rcnt_q == rdiv_q);
    rmid = (rcnt_q == (rdiv_q >> 1));
    if (rs_q != R_IDLE) rcnt_d = rend ? '0 : rcnt_q + 1'b1;
    case (rs_q)
      // The falling-edge requirement also makes a held-low break wait for rx high first.
      R_IDLE: if (rx_p_q && !rx_s_q) begin
        rs_d = R_START; rcnt_d = (CMSB+1)'(1); rdiv_d = div_eff; rnb_d = nb_eff;
        rpen_d = ^par; rodd_d = (par == 2'b10); rdat_d = '0; rperr_d = 1'b0;
      end
      R_START: begin
        if (rmid && rx_s_q) rs_d = R_IDLE;
        else if (rend) begin rs_d = R_DATA; rbit_d = '0; end
      end
      R_DATA: begin
        if (rmid) rdat_d[rbit_q] = rx_s_q;
        if (rend) begin
          rbit_d = rbit_q + 1'b1;
          if (rbit_q == rnb_q) rs_d = rpen_q ? R_PAR : R_STOP;
        end
      end
      R_PAR: begin
        if (rmid) rperr_d = rx_s_q ^ (^rdat_q) ^ rodd_q;
        if (rend) rs_d = R_STOP;
      end
      R_STOP: if (rmid) begin rstore = 1'b1; rferr = ~rx_s_q; rs_d = R_IDLE; end
      default: rs_d = R_IDLE;
    endcase
    if (kill) begin rs_d = R_IDLE; rstore = 1'b0; end
    if (clear) ovf_d = 1'b0;
    else if (rstore && rxf_full && !rx_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs_q <= R_IDLE; rcnt_q <= '0; rdiv_q <= '0; rnb_q <= '0; rbit_q <= '0; rdat_q <= '0;
      rpen_q <= 1'b0; rodd_q <= 1'b0; rperr_q <= 1'b0; ovf_q <= 1'b0;
      rx_m_q <= 1'b1; rx_s_q <= 1'b1; rx_p_q <= 1'b1;
    end else begin
      rs_q <= rs_d; rcnt_q <= rcnt_d; rdiv_q <= rdiv_d; rnb_q <= rnb_d; rbit_q <= rbit_d;
      rdat_q <= rdat_d; rpen_q <= rpen_d; rodd_q <= rodd_d; rperr_q <= rperr_d; ovf_q <= ovf_d;
      rx_m_q <= rx; rx_s_q <= rx_m_q; rx_p_q <= rx_s_q;
    end
  end

  assign rx_ovf = ovf_q;
endmodule

// File: tb/tb_uart_trx.sv
// Bench for uart_trx: directed scenarios plus random loopback frames against a bit-list frame model.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_uart_trx;
  localparam int DMSB = 7, CMSB = 12, AW = 2, W = DMSB + 1;

  logic          clk = 1'b0, rstn = 1'b0, setn = 1'b1, stop2 = 1'b0, tx_push = 1'b0;
  logic [CMSB:0] div = '0;
  logic [3:0]    nbits = '0;
  logic [1:0]    par = '0;
  logic [W-1:0]  tx_wdata = '0, rx_rdata;
  logic          tx_full, tx_empty, rx_pop = 1'b0, rx_perr, rx_ferr, rx_empty, rx_ovf;
  logic          clear = 1'b0, tx, loop = 1'b1, rx_drv = 1'b1, rx_line;
  int            ntests = 0, nfail = 0;
  int            m_div, m_nb, m_par, m_stop2;

  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_trx #(.DMSB(DMSB), .CMSB(CMSB), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .setn(setn), .div(div), .nbits(nbits), .par(par), .stop2(stop2),
    .tx_push(tx_push), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_pop(rx_pop), .rx_rdata(rx_rdata), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_empty(rx_empty), .rx_ovf(rx_ovf), .clear(clear), .tx(tx), .rx(rx_line)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference format: effective divider and data-bit count as the line should see them.
  task automatic set_fmt(input int dv, input int nb, input int p, input int s2);
    div = (CMSB+1)'(dv); nbits = 4'(nb); par = 2'(p); stop2 = 1'(s2);
    m_div = (dv < 3) ? 3 : dv;
    m_nb  = (nb > DMSB) ? DMSB : nb;
    m_par = p; m_stop2 = s2;
  endtask

  function automatic logic [W-1:0] mdata(input logic [W-1:0] d);
    return d & W'((1 << (m_nb + 1)) - 1);
  endfunction

  function automatic logic pbit(input logic [W-1:0] d);
    return (^mdata(d)) ^ (m_par == 2);
  endfunction

  function automatic bit pen();
    return (m_par == 1) || (m_par == 2);
  endfunction

  task automatic push_byte(input logic [W-1:0] d);
    tx_wdata = d; tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    int b = 0;
    while (rx_empty !== 1'b0 && b < 3000) begin @(negedge clk); b++; end
    chk({tag, " rx_avail"}, 32'(rx_empty), 0);
  endtask

  task automatic wait_tx_idle(input string tag);
    int b = 0;
    while (tx_empty !== 1'b1 && b < 3000) begin @(negedge clk); b++; end
    chk({tag, " tx_idle"}, 32'(tx_empty), 1);
  endtask

  task automatic check_rx(input string tag, input logic [W-1:0] d, input logic pe, input logic fe);
    wait_rx(tag);
    chk({tag, " data"}, 32'(rx_rdata), 32'(d));
    chk({tag, " perr"}, 32'(rx_perr), 32'(pe));
    chk({tag, " ferr"}, 32'(rx_ferr), 32'(fe));
    pop_rx();
  endtask

  // Expected line sequence: start, nb+1 data bits LSB first, optional parity, 1 or 2 stops.
  task automatic check_tx_frame(input string tag, input logic [W-1:0] d, output int last);
    logic eb[$];
    int per, cur, tgt, b;
    eb.push_back(1'b0);
    for (int i = 0; i <= m_nb; i++) eb.push_back(d[i]);
    if (pen()) eb.push_back(pbit(d));
    eb.push_back(1'b1);
    if (m_stop2 != 0) eb.push_back(1'b1);
    per = m_div + 1; b = 0; last = 0;
    while (tx !== 1'b0 && b < 3000) begin @(negedge clk); b++; end
    if (tx !== 1'b0) begin chk({tag, " start"}, 32'(tx), 0); return; end
    cur = 0;
    for (int k = 0; k < eb.size(); k++) begin
      tgt = k * per + per / 2;
      repeat (tgt - cur) @(negedge clk);
      cur = tgt;
      chk($sformatf("%s bit%0d", tag, k), 32'(tx), 32'(eb[k]));
    end
    last = cur;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_drv = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [W-1:0] d, input logic flip, input logic sv, input int sper);
    int per = m_div + 1;
    drive_bit(1'b0, per);
    for (int i = 0; i <= m_nb; i++) drive_bit(d[i], per);
    if (pen()) drive_bit(pbit(d) ^ flip, per);
    drive_bit(sv, per * sper);
    drive_bit(1'b1, per);
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] d;
    int last, b;

    set_fmt(7, 7, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 1);
    chk("rst tx_empty", 32'(tx_empty), 1);
    chk("rst tx_full", 32'(tx_full), 0);
    chk("rst rx_empty", 32'(rx_empty), 1);
    chk("rst rx_rdata", 32'(rx_rdata), 0);
    chk("rst rx_perr", 32'(rx_perr), 0);
    chk("rst rx_ferr", 32'(rx_ferr), 0);
    chk("rst rx_ovf", 32'(rx_ovf), 0);
    rstn = 1'b1;
    @(negedge clk);

    // 8N1 loopback, back-to-back frames of 80 clocks each
    push_byte(8'hA5);
    push_byte(8'h3C);
    check_tx_frame("8N1 A5", 8'hA5, last);
    repeat (79 - last) @(negedge clk);
    chk("8N1 last stop clk", 32'(tx), 1);
    @(negedge clk);
    chk("8N1 b2b start", 32'(tx), 0);
    check_tx_frame("8N1 3C", 8'h3C, last);
    check_rx("8N1 rx A5", 8'hA5, 1'b0, 1'b0);
    check_rx("8N1 rx 3C", 8'h3C, 1'b0, 1'b0);

    // 7E2, div=4
    set_fmt(4, 6, 1, 1);
    push_byte(8'h55);
    check_tx_frame("7E2 55", 8'h55, last);
    check_rx("7E2 rx 55", 8'h55, 1'b0, 1'b0);

    // random formats (including div<3 and nbits>DMSB clamping) in loopback
    for (int n = 0; n < 8; n++) begin
      set_fmt($urandom_range(0, 9), $urandom_range(4, 9), $urandom_range(0, 3), $urandom_range(0, 1));
      d = W'($urandom);
      push_byte(d);
      check_tx_frame($sformatf("rnd%0d", n), d, last);
      check_rx($sformatf("rnd%0d rx", n), mdata(d), 1'b0, 1'b0);
    end

    // TX capacity: shifter takes the first entry, FIFO holds 2**AW more, the rest is dropped
    wait_tx_idle("cap");
    set_fmt(3, 7, 0, 0);
    q.delete();
    for (int i = 0; i < 6; i++) begin
      d = W'($urandom);
      q.push_back(d);
      push_byte(d);
    end
    chk("cap tx_full", 32'(tx_full), 1);
    for (int i = 0; i < 5; i++) check_rx($sformatf("cap rx%0d", i), q[i], 1'b0, 1'b0);
    wait_tx_idle("cap end");
    repeat (60) @(negedge clk);
    chk("cap dropped 6th", 32'(rx_empty), 1);

    // direct RX: 8O1 with parity inverted
    loop = 1'b0;
    set_fmt(6, 7, 2, 0);
    send_rx(8'h01, 1'b1, 1'b1, 1);
    check_rx("8O1 badpar", 8'h01, 1'b1, 1'b0);

    // framing error with a held-low break, then a clean frame
    set_fmt(6, 7, 0, 0);
    send_rx(8'h80, 1'b0, 1'b0, 3);
    check_rx("ferr 80", 8'h80, 1'b0, 1'b1);
    send_rx(8'h12, 1'b0, 1'b1, 1);
    check_rx("after ferr 12", 8'h12, 1'b0, 1'b0);

    // overflow: 2**AW kept in order, next frame dropped
    set_fmt(3, 7, 0, 0);
    q.delete();
    for (int i = 0; i < 5; i++) begin
      d = W'($urandom);
      q.push_back(d);
      send_rx(d, 1'b0, 1'b1, 1);
      if (i == 3) chk("ovf not yet", 32'(rx_ovf), 0);
    end
    chk("ovf set", 32'(rx_ovf), 1);
    for (int i = 0; i < 4; i++) check_rx($sformatf("ovf rx%0d", i), q[i], 1'b0, 1'b0);
    chk("ovf drained", 32'(rx_empty), 1);
    send_rx(8'h77, 1'b0, 1'b1, 1);
    wait_rx("pre-clear");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear ovf", 32'(rx_ovf), 0);
    chk("clear rx_empty", 32'(rx_empty), 1);

    // reset in the middle of a data bit
    loop = 1'b1;
    set_fmt(7, 7, 0, 0);
    wait_tx_idle("mid rst");
    push_byte(8'hA5);
    b = 0;
    while (tx !== 1'b0 && b < 100) begin @(negedge clk); b++; end
    repeat (20) @(negedge clk);
    chk("pre-reset tx bit1", 32'(tx), 0);
    rstn = 1'b0;
    #1;
    chk("reset tx immediate", 32'(tx), 1);
    chk("reset tx_empty", 32'(tx_empty), 1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (120) @(negedge clk);
    chk("reset no partial rx", 32'(rx_empty), 1);
    chk("reset tx idle", 32'(tx), 1);

    // one-clock low glitch on rx
    loop = 1'b0;
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch ignored", 32'(rx_empty), 1);
    send_rx(8'h3C, 1'b0, 1'b1, 1);
    check_rx("post glitch 3C", 8'h3C, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
